seq_addsub: RTL and testbench

SEQ_ADDSUB -- requirements
Module: seq_addsub

---
 rtl/seq_addsub_pkg.sv | 16 +
 rtl/seq_addsub_chunk.sv | 33 +++
 rtl/seq_addsub.sv | 125 ++++++++++++
 tb/tb_seq_addsub.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor.
//   state_t   : FSM encoding used by seq_addsub (also exported on its debug port)
//   idx_width : width of the chunk index for a given chunk count (minimum 1)
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple-carry adder slice.
//   x, y  : CHUNK-bit addends
//   cin   : carry in
//   s     : CHUNK-bit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow)
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: sequential add/subtract, CHUNK bits per cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, sel sampled only on accept)
//   out_valid / out_ready : result handshake; sum/cout/ovf/zero held while stalled
//   fsm_state           : debug view of the FSM state
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE, so accept
// and result release never coincide (DONE -> IDLE takes a cycle).
// Subtraction is A + ~B + 1: b is inverted at accept and the carry seeded with sel.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output state_t           fsm_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = idx_width(NCH);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_addsub: WIDTH must be >= 2");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, sum_next;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last, accept;
    logic [CHUNK-1:0] cx, cy, cs;
    logic             c_out, c_msb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IW'(NCH - 1));
    assign fsm_state = state;

    always_comb begin
        cx = op_a[int'(idx) * CHUNK +: CHUNK];
        cy = op_b[int'(idx) * CHUNK +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (cx),
        .y     (cy),
        .cin   (carry),
        .s     (cs),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // Result with the current chunk merged in; also feeds the zero flag on the
    // last chunk so zero reflects the final sum in the same cycle.
    always_comb begin
        sum_next = sum;
        sum_next[int'(idx) * CHUNK +: CHUNK] = cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sel}};
            carry <= sel;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == BUSY) begin
            sum   <= sum_next;
            carry <= c_out;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) begin
                cout <= c_out;
                ovf  <= c_msb ^ c_out;
                zero <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed vector table on three builds (CHUNK 4, 16, 1),
// backpressure, reset-abandon and random scoreboard sequences.
module tb_seq_addsub;
    import seq_addsub_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index 0: CHUNK=4, 1: CHUNK=16, 2: CHUNK=1)
    logic        iv[3];
    logic        ordy[3];
    logic        ir[3];
    logic        ov[3];
    logic [15:0] sm[3];
    logic        cc[3];
    logic        of[3];
    logic        zz[3];
    state_t      st[3];
    logic [15:0] a, b;
    logic        sel;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b),
        .sel(sel), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(cc[0]),
        .ovf(of[0]), .zero(zz[0]), .fsm_state(st[0]));
    seq_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b),
        .sel(sel), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(cc[1]),
        .ovf(of[1]), .zero(zz[1]), .fsm_state(st[1]));
    seq_addsub #(.WIDTH(16), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
        .sel(sel), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(cc[2]),
        .ovf(of[2]), .zero(zz[2]), .fsm_state(st[2]));

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [18:0] exp_q[$];   // {cout, ovf, zero, sum}
    int lat_exp[3] = '{4, 1, 16};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms);
        logic [16:0] r;
        logic        o;
        if (ms) begin
            r = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
            o = (ma[15] != mb[15]) && (r[15] != ma[15]);
        end else begin
            r = {1'b0, ma} + {1'b0, mb};
            o = (ma[15] == mb[15]) && (r[15] != ma[15]);
        end
        return {r[16], o, (r[15:0] == 16'h0), r[15:0]};
    endfunction

    // ---------------- driver ----------------
    // Runs one operation on instance k, scrambles inputs right after accept,
    // holds the result for 'hold' cycles before taking it.
    task automatic run_op(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ts, input int hold,
                          output logic [18:0] res, output int lat);
        int n;
        @(negedge clk);
        a = ta; b = tb_; sel = ts; iv[k] = 1'b1;
        n = 0;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sel = 1'($urandom);
        lat = 0;
        while (!ov[k] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = {cc[k], of[k], zz[k], sm[k]};
        repeat (hold) @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vs;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        logic        ez;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [18:0] res;
        logic [18:0] exp_r;
        int          lat;
        bit          saw;

        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
        a = '0; b = '0; sel = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_sum", 32'(sm[0]), 32'h0);
        chk("rst_flags", {29'd0, cc[0], of[0], zz[0]}, 32'd0);
        chk("rst_state", 32'(st[0]), 32'(IDLE));
        rst_n = 1'b1;

        // ---- directed table on all three builds ----
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 12; v++) begin
                run_op(k, vecs[v].va, vecs[v].vb, vecs[v].vs, 0, res, lat);
                chk($sformatf("vec%0d_k%0d_sum", v, k), 32'(res[15:0]), 32'(vecs[v].es));
                chk($sformatf("vec%0d_k%0d_flags", v, k), 32'(res[18:16]),
                    {29'd0, vecs[v].ec, vecs[v].eo, vecs[v].ez});
                chk($sformatf("vec%0d_k%0d_latency", v, k), 32'(lat), 32'(lat_exp[k]));
            end
        end

        // ---- backpressure: 5 stalled cycles in DONE ----
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; sel = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            iv[0] = 1'b1; a = 16'($urandom); b = 16'($urandom); sel = 1'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_sum", c), 32'(sm[0]), 32'h8000);
            chk($sformatf("bp_hold%0d_flags", c), {29'd0, cc[0], of[0], zz[0]}, 32'b010);
            chk($sformatf("bp_hold%0d_valid_ready", c), {30'd0, ov[0], ir[0]}, 32'b10);
        end
        // in_valid still high on the release edge: must land in IDLE, not BUSY
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        chk("bp_release_state", 32'(st[0]), 32'(IDLE));
        chk("bp_release_valid_ready", {30'd0, ov[0], ir[0]}, 32'b01);

        // ---- reset in second BUSY cycle ----
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; sel = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_sum", 32'(sm[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ov[0]) saw = 1'b1;
        end
        chk("midrst_no_result", 32'(saw), 32'd0);

        // ---- accept on the first edge after reset release ----
        @(negedge clk);
        rst_n = 1'b0;
        a = 16'h1234; b = 16'h1111; sel = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("post_rst_accept", 32'(ir[0]), 32'd0);
        lat = 0;
        while (!ov[0] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_sum", 32'(sm[0]), 32'h2345);
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;

        // ---- random operations against the reference model ----
        for (int r = 0; r < 300; r++) begin
            logic [15:0] ra, rb;
            logic        rs;
            int          k;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            k  = (r < 200) ? 0 : $urandom_range(1, 2);
            exp_q.push_back(model(ra, rb, rs));
            run_op(k, ra, rb, rs, $urandom_range(0, 3), res, lat);
            exp_r = exp_q.pop_front();
            chk($sformatf("rand%0d_k%0d_result", r, k), 32'(res), 32'(exp_r));
            chk($sformatf("rand%0d_k%0d_latency", r, k), 32'(lat), 32'(lat_exp[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
